// File: rtl/game_level_sequencer_pkg.sv
// Shared types and helpers for the game flow controller: state enum, external state codes,
// saturation limits, popcount and saturating arithmetic.
package game_pkg;

    typedef enum logic [2:0] {
        S_START,
        S_PLAY,
        S_TRANS,
        S_VICTORY,
        S_DEATH
    } state_t;

    localparam logic [2:0] GS_START   = 3'd0;
    localparam logic [2:0] GS_PLAY    = 3'd1;
    localparam logic [2:0] GS_TRANS   = 3'd2;
    localparam logic [2:0] GS_VICTORY = 3'd4;
    localparam logic [2:0] GS_DEATH   = 3'd5;

    localparam int SPEED_MAX = 2047;
    localparam int TREE_MAX  = 15;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] b);
        return (b >= a) ? 4'd0 : (a - b);
    endfunction

    function automatic int level_value(input int base, input int step, input int lvl, input int lim);
        int v;
        v = base + lvl * step;
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [2:0] state_code(input state_t s);
        logic [2:0] c;
        c = GS_START;
        case (s)
            S_PLAY:    c = GS_PLAY;
            S_TRANS:   c = GS_TRANS;
            S_VICTORY: c = GS_VICTORY;
            S_DEATH:   c = GS_DEATH;
            default:   c = GS_START;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/game_level_sequencer_if.sv
// Game-flow bus between the level sequencer (master) and the drawing/enemy logic (slave).
interface game_level_sequencer_if #(
    parameter int ENEMY_CH = 3
);
    logic [2:0]          currLife;
    logic [ENEMY_CH-1:0] shotEnemyCollision;
    logic                slowClk;
    logic                playerTrigger;
    logic                pauseReq;
    logic                pause;
    logic                start_screen;
    logic                death_screen;
    logic                victory_screen;
    logic [2:0]          currentGameState;
    logic [2:0]          cur_level;
    logic [3:0]          enemiesLeft;
    logic [3:0]          tree_count;
    logic [10:0]         curEnemySpeed;
    logic                newLevel;

    modport master (
        input  currLife, shotEnemyCollision, slowClk, playerTrigger, pauseReq,
        output pause, start_screen, death_screen, victory_screen, currentGameState,
               cur_level, enemiesLeft, tree_count, curEnemySpeed, newLevel
    );

    modport slave (
        output currLife, shotEnemyCollision, slowClk, playerTrigger, pauseReq,
        input  pause, start_screen, death_screen, victory_screen, currentGameState,
               cur_level, enemiesLeft, tree_count, curEnemySpeed, newLevel
    );
endinterface

// File: rtl/game_level_sequencer_tick_timer.sv
// Inter-level delay: after a start pulse, counts tick strobes and flags done on the TICKS-th one.
module game_tick_timer #(
    parameter int TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    output logic done
);
    logic       running_reg;
    logic [7:0] count_reg;

    // done is combinational so the owner can leave its wait state in the same cycle as the final tick
    assign done = running_reg & tick & (count_reg == 8'(TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            running_reg <= 1'b0;
            count_reg   <= '0;
        end else if (start) begin
            running_reg <= 1'b1;
            count_reg   <= '0;
        end else if (running_reg && tick) begin
            if (done) begin
                running_reg <= 1'b0;
                count_reg   <= '0;
            end else begin
                count_reg <= count_reg + 8'd1;
            end
        end
    end
endmodule

// File: rtl/game_level_sequencer.sv
// Game flow controller: START -> NUM_LEVELS levels -> VICTORY / DEATH, with difficulty per level.
// Optional user pause in PLAY is enabled by defining GAME_PAUSE_EN.
module game_level_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS      = 4,
    parameter int ENEMY_CH        = 3,
    parameter int ENEMIES_PER_LVL = 2,
    parameter int SPEED_BASE      = 120,
    parameter int SPEED_STEP      = 120,
    parameter int TREE_BASE       = 8,
    parameter int TREE_STEP       = 1,
    parameter int TRANS_TICKS     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    game_level_sequencer_if.master bus
);
    localparam logic [3:0] LEFT_RELOAD = 4'(ENEMIES_PER_LVL);
    localparam logic [2:0] LAST_LEVEL  = 3'(NUM_LEVELS - 1);

    state_t     state_reg, state_next;
    logic [2:0] level_reg, level_next;
    logic [3:0] left_reg, left_next;
    logic       new_level_reg, new_level_next;
    logic       trig_q_reg;
    logic       trig_rise;
    logic       timer_start, timer_done;
    logic       frozen;
    logic [3:0] hits;

    assign trig_rise = bus.playerTrigger & ~trig_q_reg;
    assign hits      = popcount8(8'(bus.shotEnemyCollision));

    game_tick_timer #(.TICKS(TRANS_TICKS)) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .tick  (bus.slowClk),
        .done  (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_START;
            level_reg     <= '0;
            left_reg      <= LEFT_RELOAD;
            new_level_reg <= 1'b0;
            trig_q_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            level_reg     <= level_next;
            left_reg      <= left_next;
            new_level_reg <= new_level_next;
            trig_q_reg    <= bus.playerTrigger;
        end
    end

    always_comb begin
        state_next     = state_reg;
        level_next     = level_reg;
        left_next      = left_reg;
        new_level_next = 1'b0;
        timer_start    = 1'b0;
        case (state_reg)
            S_START, S_VICTORY: begin
                if (trig_rise) begin
                    state_next     = S_PLAY;
                    level_next     = '0;
                    left_next      = LEFT_RELOAD;
                    new_level_next = 1'b1;
                end
            end
            S_PLAY: begin
                // A dead player's final hit does not count: the level stays uncleared
                if (!frozen) begin
                    if (bus.currLife == 3'd0) begin
                        state_next = S_DEATH;
                    end else begin
                        left_next = sat_sub4(left_reg, hits);
                        if (left_next == 4'd0) begin
                            if (level_reg == LAST_LEVEL) begin
                                state_next = S_VICTORY;
                            end else begin
                                state_next  = S_TRANS;
                                timer_start = 1'b1;
                            end
                        end
                    end
                end
            end
            S_TRANS: begin
                if (timer_done) begin
                    state_next     = S_PLAY;
                    level_next     = level_reg + 3'd1;
                    left_next      = LEFT_RELOAD;
                    new_level_next = 1'b1;
                end
            end
            S_DEATH: begin
                if (trig_rise) begin
                    state_next = S_START;
                    level_next = '0;
                    left_next  = LEFT_RELOAD;
                end
            end
            default: state_next = S_START;
        endcase
    end

`ifdef GAME_PAUSE_EN
    logic pause_q_reg;
    logic user_pause_reg, user_pause_next;

    always_comb begin
        user_pause_next = user_pause_reg;
        if (state_reg != S_PLAY || state_next != S_PLAY) begin
            user_pause_next = 1'b0;
        end else if (bus.pauseReq && !pause_q_reg) begin
            user_pause_next = ~user_pause_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pause_q_reg    <= 1'b0;
            user_pause_reg <= 1'b0;
        end else begin
            pause_q_reg    <= bus.pauseReq;
            user_pause_reg <= user_pause_next;
        end
    end

    assign frozen = user_pause_reg;
`else
    assign frozen = 1'b0;
`endif

    // Every output is decoded from registers only, so there is no input-to-output path
    assign bus.pause            = (state_reg != S_PLAY) | frozen;
    assign bus.start_screen     = (state_reg == S_START);
    assign bus.death_screen     = (state_reg == S_DEATH);
    assign bus.victory_screen   = (state_reg == S_VICTORY);
    assign bus.currentGameState = state_code(state_reg);
    assign bus.cur_level        = level_reg;
    assign bus.enemiesLeft      = left_reg;
    assign bus.newLevel         = new_level_reg;
    assign bus.curEnemySpeed    = 11'(level_value(SPEED_BASE, SPEED_STEP, int'(level_reg), SPEED_MAX));
    assign bus.tree_count       = 4'(level_value(TREE_BASE, TREE_STEP, int'(level_reg), TREE_MAX));

endmodule

// File: tb/tb_game_level_sequencer.sv
// Bench for game_level_sequencer: vector table, hand-written level sequences, and random
// stimulus checked every cycle against a rule-level reference model.
module tb_game_level_sequencer;
    localparam int NUM_LEVELS      = 4;
    localparam int ENEMY_CH        = 3;
    localparam int ENEMIES_PER_LVL = 2;
    localparam int SPEED_BASE      = 120;
    localparam int SPEED_STEP      = 120;
    localparam int TREE_BASE       = 8;
    localparam int TREE_STEP       = 1;
    localparam int TRANS_TICKS     = 3;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_level_sequencer_if #(.ENEMY_CH(ENEMY_CH)) bus ();

    game_level_sequencer #(
        .NUM_LEVELS(NUM_LEVELS), .ENEMY_CH(ENEMY_CH), .ENEMIES_PER_LVL(ENEMIES_PER_LVL),
        .SPEED_BASE(SPEED_BASE), .SPEED_STEP(SPEED_STEP), .TREE_BASE(TREE_BASE),
        .TREE_STEP(TREE_STEP), .TRANS_TICKS(TRANS_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state: state code as seen on currentGameState
    int m_state, m_level, m_left, m_ticks;
    bit m_tprev, m_pprev, m_upause, m_nl;

    typedef struct {
        bit       r;
        bit       t;
        bit [2:0] life;
        bit [2:0] hits;
        bit       s;
        int       st;
        int       lvl;
        int       left;
        int       pause;
        int       nl;
        int       speed;
        int       tree;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic begin_level(input int n);
        m_state = 1;
        m_level = n;
        m_left  = ENEMIES_PER_LVL;
        m_ticks = 0;
        m_nl    = 1'b1;
    endtask

    task automatic model_update(input bit r, input bit t, input bit [2:0] life,
                                input bit [2:0] hits, input bit s, input bit p);
        bit rise, prise;
        int prev, n;
        rise    = t && !m_tprev;
        prise   = p && !m_pprev;
        m_tprev = t;
        m_pprev = p;
        m_nl    = 1'b0;
        if (r) begin
            m_state = 0; m_level = 0; m_left = ENEMIES_PER_LVL; m_ticks = 0;
            m_tprev = 1'b0; m_pprev = 1'b0; m_upause = 1'b0;
            return;
        end
        prev = m_state;
        case (m_state)
            0, 4: if (rise) begin_level(0);
            1: if (!m_upause) begin
                if (life == 0) begin
                    m_state = 5;
                end else begin
                    n      = $countones(hits);
                    m_left = (n >= m_left) ? 0 : m_left - n;
                    if (m_left == 0) begin
                        if (m_level == NUM_LEVELS - 1) m_state = 4;
                        else begin m_state = 2; m_ticks = 0; end
                    end
                end
            end
            2: if (s) begin
                m_ticks++;
                if (m_ticks == TRANS_TICKS) begin_level(m_level + 1);
            end
            5: if (rise) begin m_state = 0; m_level = 0; m_left = ENEMIES_PER_LVL; end
            default: m_state = 0;
        endcase
        if (PAUSE_EN && prev == 1 && m_state == 1 && prise) m_upause = !m_upause;
        if (m_state != 1) m_upause = 1'b0;
    endtask

    task automatic compare_model();
        check("state", 32'(bus.currentGameState), 32'(m_state));
        check("level", 32'(bus.cur_level), 32'(m_level));
        check("left", 32'(bus.enemiesLeft), 32'(m_left));
        check("pause", 32'(bus.pause), 32'((m_state != 1) || m_upause));
        check("start_screen", 32'(bus.start_screen), 32'(m_state == 0));
        check("victory_screen", 32'(bus.victory_screen), 32'(m_state == 4));
        check("death_screen", 32'(bus.death_screen), 32'(m_state == 5));
        check("newLevel", 32'(bus.newLevel), 32'(m_nl));
        check("speed", 32'(bus.curEnemySpeed), 32'(min_i(SPEED_BASE + m_level * SPEED_STEP, 2047)));
        check("trees", 32'(bus.tree_count), 32'(min_i(TREE_BASE + m_level * TREE_STEP, 15)));
    endtask

    task automatic step(input bit r, input bit t, input bit [2:0] life,
                        input bit [2:0] hits, input bit s, input bit p);
        reset                  = r;
        bus.playerTrigger      = t;
        bus.currLife           = life;
        bus.shotEnemyCollision = hits;
        bus.slowClk            = s;
        bus.pauseReq           = p;
        @(posedge clk);
        model_update(r, t, life, hits, s, p);
        #1;
        compare_model();
        $display("cyc r=%0d t=%0d life=%0d hits=%b slow=%0d p=%0d -> st=%0d lvl=%0d left=%0d pause=%0d nl=%0d",
                 r, t, life, hits, s, p, bus.currentGameState, bus.cur_level,
                 bus.enemiesLeft, bus.pause, bus.newLevel);
    endtask

    // clear the current level in one cycle, then wait out the transition
    task automatic clear_and_advance(input int lv);
        step(0, 0, 3, 3'b111, 0, 0);
        check("clear_to_trans", 32'(bus.currentGameState), 32'd2);
        repeat (TRANS_TICKS) step(0, 0, 3, 3'b000, 1, 0);
        check("adv_level", 32'(bus.cur_level), 32'(lv + 1));
        check("adv_newLevel", 32'(bus.newLevel), 32'd1);
        check("adv_speed", 32'(bus.curEnemySpeed), 32'(SPEED_BASE + (lv + 1) * SPEED_STEP));
        check("adv_trees", 32'(bus.tree_count), 32'(TREE_BASE + (lv + 1) * TREE_STEP));
    endtask

    initial begin
        reset = 1'b1;
        bus.playerTrigger = 1'b0; bus.currLife = 3'd3; bus.shotEnemyCollision = '0;
        bus.slowClk = 1'b0; bus.pauseReq = 1'b0;
        m_state = 0; m_level = 0; m_left = ENEMIES_PER_LVL; m_ticks = 0;
        m_tprev = 0; m_pprev = 0; m_upause = 0; m_nl = 0;

        //          r t life hits   s   st lvl left pause nl speed tree
        vecs[0]  = '{1, 0, 3, 3'b000, 0, 0, 0, 2, 1, 0, 120, 8};
        vecs[1]  = '{0, 1, 3, 3'b000, 0, 1, 0, 2, 0, 1, 120, 8};
        vecs[2]  = '{0, 1, 3, 3'b000, 0, 1, 0, 2, 0, 0, 120, 8};
        vecs[3]  = '{0, 1, 3, 3'b000, 0, 1, 0, 2, 0, 0, 120, 8};
        vecs[4]  = '{0, 0, 3, 3'b011, 0, 2, 0, 0, 1, 0, 120, 8};
        vecs[5]  = '{0, 0, 3, 3'b000, 1, 2, 0, 0, 1, 0, 120, 8};
        vecs[6]  = '{0, 0, 3, 3'b000, 0, 2, 0, 0, 1, 0, 120, 8};
        vecs[7]  = '{0, 0, 3, 3'b000, 1, 2, 0, 0, 1, 0, 120, 8};
        vecs[8]  = '{0, 0, 3, 3'b000, 1, 1, 1, 2, 0, 1, 240, 9};
        vecs[9]  = '{0, 0, 3, 3'b001, 0, 1, 1, 1, 0, 0, 240, 9};
        vecs[10] = '{0, 0, 0, 3'b001, 0, 5, 1, 1, 1, 0, 240, 9};
        vecs[11] = '{0, 1, 3, 3'b000, 0, 0, 0, 2, 1, 0, 120, 8};
        vecs[12] = '{0, 1, 3, 3'b000, 0, 0, 0, 2, 1, 0, 120, 8};
        vecs[13] = '{0, 0, 3, 3'b111, 0, 0, 0, 2, 1, 0, 120, 8};
        vecs[14] = '{0, 1, 3, 3'b000, 0, 1, 0, 2, 0, 1, 120, 8};
        vecs[15] = '{0, 0, 3, 3'b100, 0, 1, 0, 1, 0, 0, 120, 8};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].r, vecs[i].t, vecs[i].life, vecs[i].hits, vecs[i].s, 0);
            check("vec_state", 32'(bus.currentGameState), 32'(vecs[i].st));
            check("vec_level", 32'(bus.cur_level), 32'(vecs[i].lvl));
            check("vec_left", 32'(bus.enemiesLeft), 32'(vecs[i].left));
            check("vec_pause", 32'(bus.pause), 32'(vecs[i].pause));
            check("vec_newLevel", 32'(bus.newLevel), 32'(vecs[i].nl));
            check("vec_speed", 32'(bus.curEnemySpeed), 32'(vecs[i].speed));
            check("vec_trees", 32'(bus.tree_count), 32'(vecs[i].tree));
        end

        // full run to victory, then replay from level 0
        for (int lv = 0; lv < NUM_LEVELS - 1; lv++) clear_and_advance(lv);
        step(0, 0, 3, 3'b111, 0, 0);
        check("victory_state", 32'(bus.currentGameState), 32'd4);
        check("victory_screen", 32'(bus.victory_screen), 32'd1);
        step(0, 1, 3, 3'b000, 0, 0);
        check("replay_state", 32'(bus.currentGameState), 32'd1);
        check("replay_level", 32'(bus.cur_level), 32'd0);
        step(0, 0, 3, 3'b000, 0, 0);

        // reset part-way through the transition out of level 2
        clear_and_advance(0);
        clear_and_advance(1);
        step(0, 0, 3, 3'b111, 0, 0);
        step(0, 0, 3, 3'b000, 1, 0);
        check("midtrans_level", 32'(bus.cur_level), 32'd2);
        step(1, 0, 3, 3'b000, 1, 0);
        check("rst_state", 32'(bus.currentGameState), 32'd0);
        check("rst_level", 32'(bus.cur_level), 32'd0);
        check("rst_left", 32'(bus.enemiesLeft), 32'(ENEMIES_PER_LVL));
        step(0, 1, 3, 3'b000, 0, 0);
        step(0, 0, 3, 3'b111, 0, 0);
        repeat (TRANS_TICKS - 1) step(0, 0, 3, 3'b000, 1, 0);
        check("timer_cleared", 32'(bus.currentGameState), 32'd2);
        step(0, 0, 3, 3'b000, 1, 0);
        check("timer_done", 32'(bus.currentGameState), 32'd1);

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 31) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
                 ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
